dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
- Decoded-instruction buffer between the decoder and the two scheduling structures: the ALU reservation station and the load/store buffer.
- Accepts one instruction per cycle into an in-order FIFO.
- Keeps queued operands current by snooping both CDBs.
- Dispatches the head each cycle the target structure reports a free slot, driving that structure's assignment_ena plus operand fields.
- Decouples decoder stalls from RS/LSB occupancy and gives branch-mispredict flush one clearing point.

Parameters:
- DEPTH, 4, queue entries (power of two, >=2)
- DATA_WIDTH, 32, operand/imm/pc width
- OP_WIDTH, 6, operation code width
- ROB_WIDTH, 4, ROB tag width; tag 0 = "no dependency / value valid"

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ena  in  1  global enable; low freezes all state
- flush  in  1  mispredict clear
- in_valid  in  1  decoder presents instruction
- in_op  in  OP_WIDTH  operation
- in_imm, in_pc  in  DATA_WIDTH  immediate, pc
- in_Qj, in_Qk  in  ROB_WIDTH  source tags
- in_Vj, in_Vk  in  DATA_WIDTH  source values
- in_rd_rob  in  ROB_WIDTH  destination ROB tag
- in_has_rd_dest  in  1  instruction writes rd
- in_is_ls  in  1  1 = route to LSB, 0 = route to RS
- out_ready  out  1  queue can accept (count < DEPTH)
- in_alu_cdb_rob_tag / in_alu_cdb_data  in  ROB_WIDTH / DATA_WIDTH  ALU CDB
- in_ls_cdb_rob_tag / in_ls_cdb_data  in  ROB_WIDTH / DATA_WIDTH  LS CDB
- rs_has_capacity, lsb_has_capacity  in  1  high = target has a free slot this cycle
- rs_assign_ena, lsb_assign_ena  out  1  one-cycle dispatch strobes (registered)
- out_op  out  OP_WIDTH  dispatched operation
- out_Qj, out_Qk  out  ROB_WIDTH  dispatched tags
- out_Vj, out_Vk  out  DATA_WIDTH  dispatched values
- out_imm, out_pc  out  DATA_WIDTH  dispatched imm, pc
- out_rd_rob  out  ROB_WIDTH  in_has_rd_dest ? in_rd_rob : 0
- out_count  out  clog2(DEPTH)+1  occupancy, for debug/perf

Behaviour:
- Reset (async, rst=1):
  - head=tail=count=0.
  - Both assign strobes 0.
  - All out_* data = 0.
  - out_ready = 1 after release.
- Push:
  - Condition: ena & in_valid & out_ready & ~flush.
  - Entry written at tail; tail wraps modulo DEPTH.
  - out_ready depends on count only, not on same-cycle pop. Full queue rejects even if popping.
- Snoop, every ena cycle, for every valid entry and the incoming entry:
  - A nonzero Q equal to a CDB tag is replaced by 0 and its V by that CDB's data.
  - If both CDBs match, the LS CDB wins.
  - CDB tag 0 never matches.
- Pop/dispatch:
  - Condition: ena & ~flush & count>0 & (head.is_ls ? lsb_has_capacity : rs_has_capacity).
  - At that edge, the matching strobe <= 1 and the out_* fields <= head fields after same-cycle snoop, so a broadcast coinciding with dispatch is never lost.
  - head++ (wrap). The other strobe <= 0.
  - No dispatch → both strobes <= 0; data outputs hold.
  - At most one dispatch per cycle, strictly in order; the head blocks younger entries (no bypass across targets).
- Empty-queue push: the entry becomes dispatchable the next cycle (minimum latency in_valid → strobe = 2 edges).
- Simultaneous push+pop: count unchanged.
- flush=1 (with ena):
  - head=tail=count=0; strobes <= 0.
  - The in-flight input is discarded.
  - flush overrides push, pop and snoop.
- ena=0:
  - No state change.
  - Strobes <= 0, so no duplicate dispatch.
- rst asserted mid-dispatch: strobes drop immediately (asynchronous).

Decomposition:
- Shared package/constant file:
  - ZERO_ROB (0), DATA_WIDTH, ROB_WIDTH, OP_WIDTH
  - NOP opcode
  - queue-entry record {op, Qj, Qk, Vj, Vk, imm, pc, rd_rob, is_ls}
- Sub-module operand_snoop:
  - Combinational.
  - One (Q,V) pair against two CDBs → updated (Q,V).
  - Instantiated 2×(DEPTH+1).

Test Plan:
- Reset, then push ALU add (Qj=Qk=0, Vj=5, Vk=7) with rs_has_capacity=1 → rs_assign_ena pulses exactly one cycle, 2 edges after push; out_Vj=5, out_Vk=7, lsb_assign_ena stays 0.
- Push 4 entries with rs_has_capacity=0 → out_ready=0, out_count=4, 5th push ignored; raise capacity → 4 in-order strobes, entry order preserved, out_ready returns 1 after first pop.
- Queued entry Qj=3; alu CDB tag=3 data=0xDEAD while queued → dispatched out_Qj=0, out_Vj=0xDEAD; repeat with broadcast on the exact dispatch cycle → same result.
- Both CDBs carry tag 5 (alu 0x11, ls 0x22) against Qk=5 → out_Vk=0x22.
- Head is_ls=1 with lsb_has_capacity=0, next entry ALU with rs capacity=1 → no dispatch (head blocks); enable LSB → lsb strobe then rs strobe on consecutive cycles.
- 3 entries queued, flush with in_valid=1 → count=0, no strobes next cycle; ena=0 with pending head → no strobe, state unchanged; rst pulse mid-stream → strobes 0 asynchronously, count=0.

Source files
------------

// File: rtl/dispatch_queue_pkg.sv
// Shared widths, opcodes and the queue-entry record for the dispatch queue.
// Also holds the tag-match rule used by every operand snooper.
package dispatch_queue_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OP_WIDTH   = 6;
    localparam int ROB_WIDTH  = 4;

    localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;
    localparam logic [OP_WIDTH-1:0]  OP_NOP   = '0;

    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [ROB_WIDTH-1:0]  qj;
        logic [ROB_WIDTH-1:0]  qk;
        logic [DATA_WIDTH-1:0] vj;
        logic [DATA_WIDTH-1:0] vk;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] pc;
        logic [ROB_WIDTH-1:0]  rd_rob;
        logic                  is_ls;
    } entry_t;

    // Tag 0 means "value already valid", so it can never be woken up.
    function automatic logic tag_hit(input logic [ROB_WIDTH-1:0] q,
                                     input logic [ROB_WIDTH-1:0] tag);
        return (q != ZERO_ROB) && (q == tag);
    endfunction

endpackage

// File: rtl/dispatch_queue_operand_snoop.sv
// Combinational wake-up of one (Q,V) operand pair against the ALU and LS CDBs.
// The LS CDB takes priority when both broadcast the awaited tag.
module dispatch_queue_operand_snoop
    import dispatch_queue_pkg::*;
(
    input  logic [ROB_WIDTH-1:0]  i_q,
    input  logic [DATA_WIDTH-1:0] i_v,
    input  logic [ROB_WIDTH-1:0]  i_alu_tag,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    input  logic [ROB_WIDTH-1:0]  i_ls_tag,
    input  logic [DATA_WIDTH-1:0] i_ls_data,
    output logic [ROB_WIDTH-1:0]  o_q,
    output logic [DATA_WIDTH-1:0] o_v
);

    always_comb begin
        o_q = i_q;
        o_v = i_v;
        if (tag_hit(i_q, i_ls_tag)) begin
            o_q = ZERO_ROB;
            o_v = i_ls_data;
        end else if (tag_hit(i_q, i_alu_tag)) begin
            o_q = ZERO_ROB;
            o_v = i_alu_data;
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order decoded-instruction FIFO feeding the ALU reservation station and
// the load/store buffer, with CDB snooping on every queued and incoming entry.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [OP_WIDTH-1:0]      in_op,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    input  logic [ROB_WIDTH-1:0]     in_Qj,
    input  logic [ROB_WIDTH-1:0]     in_Qk,
    input  logic [DATA_WIDTH-1:0]    in_Vj,
    input  logic [DATA_WIDTH-1:0]    in_Vk,
    input  logic [ROB_WIDTH-1:0]     in_rd_rob,
    input  logic                     in_has_rd_dest,
    input  logic                     in_is_ls,
    output logic                     out_ready,
    input  logic [ROB_WIDTH-1:0]     in_alu_cdb_rob_tag,
    input  logic [DATA_WIDTH-1:0]    in_alu_cdb_data,
    input  logic [ROB_WIDTH-1:0]     in_ls_cdb_rob_tag,
    input  logic [DATA_WIDTH-1:0]    in_ls_cdb_data,
    input  logic                     rs_has_capacity,
    input  logic                     lsb_has_capacity,
    output logic                     rs_assign_ena,
    output logic                     lsb_assign_ena,
    output logic [OP_WIDTH-1:0]      out_op,
    output logic [ROB_WIDTH-1:0]     out_Qj,
    output logic [ROB_WIDTH-1:0]     out_Qk,
    output logic [DATA_WIDTH-1:0]    out_Vj,
    output logic [DATA_WIDTH-1:0]    out_Vk,
    output logic [DATA_WIDTH-1:0]    out_imm,
    output logic [DATA_WIDTH-1:0]    out_pc,
    output logic [ROB_WIDTH-1:0]     out_rd_rob,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    entry_t          r_mem [DEPTH];
    entry_t          r_out;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_rs_assign;
    logic            r_lsb_assign;

    entry_t          w_snoop [DEPTH];
    entry_t          w_in_raw;
    entry_t          w_in_entry;
    entry_t          w_head;
    logic            w_head_cap;
    logic            w_push;
    logic            w_pop;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ROB_WIDTH-1:0]  w_qj, w_qk;
            logic [DATA_WIDTH-1:0] w_vj, w_vk;

            dispatch_queue_operand_snoop u_snoop_j (
                .i_q        (r_mem[gi].qj),
                .i_v        (r_mem[gi].vj),
                .i_alu_tag  (in_alu_cdb_rob_tag),
                .i_alu_data (in_alu_cdb_data),
                .i_ls_tag   (in_ls_cdb_rob_tag),
                .i_ls_data  (in_ls_cdb_data),
                .o_q        (w_qj),
                .o_v        (w_vj)
            );

            dispatch_queue_operand_snoop u_snoop_k (
                .i_q        (r_mem[gi].qk),
                .i_v        (r_mem[gi].vk),
                .i_alu_tag  (in_alu_cdb_rob_tag),
                .i_alu_data (in_alu_cdb_data),
                .i_ls_tag   (in_ls_cdb_rob_tag),
                .i_ls_data  (in_ls_cdb_data),
                .o_q        (w_qk),
                .o_v        (w_vk)
            );

            assign w_snoop[gi] = '{op: r_mem[gi].op, qj: w_qj, qk: w_qk,
                                   vj: w_vj, vk: w_vk, imm: r_mem[gi].imm,
                                   pc: r_mem[gi].pc, rd_rob: r_mem[gi].rd_rob,
                                   is_ls: r_mem[gi].is_ls};
        end
    endgenerate

    assign w_in_raw = '{op: in_op, qj: in_Qj, qk: in_Qk, vj: in_Vj, vk: in_Vk,
                        imm: in_imm, pc: in_pc,
                        rd_rob: in_has_rd_dest ? in_rd_rob : ZERO_ROB,
                        is_ls: in_is_ls};

    // The incoming instruction is woken up too, so a broadcast in its push cycle is kept.
    logic [ROB_WIDTH-1:0]  w_in_qj, w_in_qk;
    logic [DATA_WIDTH-1:0] w_in_vj, w_in_vk;

    dispatch_queue_operand_snoop u_snoop_in_j (
        .i_q        (w_in_raw.qj),
        .i_v        (w_in_raw.vj),
        .i_alu_tag  (in_alu_cdb_rob_tag),
        .i_alu_data (in_alu_cdb_data),
        .i_ls_tag   (in_ls_cdb_rob_tag),
        .i_ls_data  (in_ls_cdb_data),
        .o_q        (w_in_qj),
        .o_v        (w_in_vj)
    );

    dispatch_queue_operand_snoop u_snoop_in_k (
        .i_q        (w_in_raw.qk),
        .i_v        (w_in_raw.vk),
        .i_alu_tag  (in_alu_cdb_rob_tag),
        .i_alu_data (in_alu_cdb_data),
        .i_ls_tag   (in_ls_cdb_rob_tag),
        .i_ls_data  (in_ls_cdb_data),
        .o_q        (w_in_qk),
        .o_v        (w_in_vk)
    );

    assign w_in_entry = '{op: w_in_raw.op, qj: w_in_qj, qk: w_in_qk,
                          vj: w_in_vj, vk: w_in_vk, imm: w_in_raw.imm,
                          pc: w_in_raw.pc, rd_rob: w_in_raw.rd_rob,
                          is_ls: w_in_raw.is_ls};

    assign w_head     = w_snoop[r_head];
    assign w_head_cap = w_head.is_ls ? lsb_has_capacity : rs_has_capacity;
    assign out_ready  = (r_count != FULL_COUNT);
    assign w_push     = ena & in_valid & out_ready & ~flush;
    assign w_pop      = ena & ~flush & (r_count != '0) & w_head_cap;

    // Entry payload needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (ena && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_snoop[i];
            end
            if (w_push) begin
                r_mem[r_tail] <= w_in_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_rs_assign  <= 1'b0;
            r_lsb_assign <= 1'b0;
            r_out        <= '0;
        end else if (!ena) begin
            r_rs_assign  <= 1'b0;
            r_lsb_assign <= 1'b0;
        end else if (flush) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_rs_assign  <= 1'b0;
            r_lsb_assign <= 1'b0;
        end else begin
            r_rs_assign  <= w_pop & ~w_head.is_ls;
            r_lsb_assign <= w_pop &  w_head.is_ls;
            if (w_pop) begin
                r_out  <= w_head;
                r_head <= r_head + PW'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign rs_assign_ena  = r_rs_assign;
    assign lsb_assign_ena = r_lsb_assign;
    assign out_op         = r_out.op;
    assign out_Qj         = r_out.qj;
    assign out_Qk         = r_out.qk;
    assign out_Vj         = r_out.vj;
    assign out_Vk         = r_out.vk;
    assign out_imm        = r_out.imm;
    assign out_pc         = r_out.pc;
    assign out_rd_rob     = r_out.rd_rob;
    assign out_count      = r_count;

endmodule

// File: tb/tb_dispatch_queue.sv
// Scenario bench for dispatch_queue: expected dispatches are queued as stimulus
// is driven and matched against every strobe seen on the falling clock edge.
module tb_dispatch_queue;

    typedef struct packed {
        logic        is_ls;
        logic [5:0]  op;
        logic [3:0]  qj;
        logic [31:0] vj;
        logic [3:0]  qk;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rd;
    } disp_t;

    logic        clk = 1'b0;
    logic        rst, ena, flush, in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_imm, in_pc, in_Vj, in_Vk;
    logic [3:0]  in_Qj, in_Qk, in_rd_rob;
    logic        in_has_rd_dest, in_is_ls, out_ready;
    logic [3:0]  alu_tag, ls_tag;
    logic [31:0] alu_data, ls_data;
    logic        rs_cap, lsb_cap, rs_assign_ena, lsb_assign_ena;
    logic [5:0]  out_op;
    logic [3:0]  out_Qj, out_Qk, out_rd_rob;
    logic [31:0] out_Vj, out_Vk, out_imm, out_pc;
    logic [2:0]  out_count;

    disp_t exp_q[$];
    disp_t obs_q[$];
    int    obs_cyc[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    dispatch_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .flush(flush),
        .in_valid(in_valid), .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc),
        .in_Qj(in_Qj), .in_Qk(in_Qk), .in_Vj(in_Vj), .in_Vk(in_Vk),
        .in_rd_rob(in_rd_rob), .in_has_rd_dest(in_has_rd_dest), .in_is_ls(in_is_ls),
        .out_ready(out_ready),
        .in_alu_cdb_rob_tag(alu_tag), .in_alu_cdb_data(alu_data),
        .in_ls_cdb_rob_tag(ls_tag), .in_ls_cdb_data(ls_data),
        .rs_has_capacity(rs_cap), .lsb_has_capacity(lsb_cap),
        .rs_assign_ena(rs_assign_ena), .lsb_assign_ena(lsb_assign_ena),
        .out_op(out_op), .out_Qj(out_Qj), .out_Qk(out_Qk),
        .out_Vj(out_Vj), .out_Vk(out_Vk), .out_imm(out_imm), .out_pc(out_pc),
        .out_rd_rob(out_rd_rob), .out_count(out_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rs_assign_ena || lsb_assign_ena) begin
            obs_q.push_back('{lsb_assign_ena, out_op, out_Qj, out_Vj, out_Qk,
                              out_Vk, out_imm, out_pc, out_rd_rob});
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic disp_t mk(input logic is_ls, input logic [5:0] op,
                                 input logic [3:0] qj, input logic [31:0] vj,
                                 input logic [3:0] qk, input logic [31:0] vk,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [3:0] rd);
        disp_t d;
        d.is_ls = is_ls; d.op = op; d.qj = qj; d.vj = vj; d.qk = qk;
        d.vk = vk; d.imm = imm; d.pc = pc; d.rd = rd;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input disp_t d, input logic has_rd, input disp_t e,
                            input bit do_exp);
        in_op = d.op; in_Qj = d.qj; in_Vj = d.vj; in_Qk = d.qk; in_Vk = d.vk;
        in_imm = d.imm; in_pc = d.pc; in_rd_rob = d.rd;
        in_has_rd_dest = has_rd; in_is_ls = d.is_ls;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (do_exp) exp_q.push_back(e);
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && obs_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_op = '0; in_imm = '0; in_pc = '0; in_Qj = '0; in_Qk = '0;
        in_Vj = '0; in_Vk = '0; in_rd_rob = '0; in_has_rd_dest = 1'b0;
        in_is_ls = 1'b0; alu_tag = '0; alu_data = '0; ls_tag = '0; ls_data = '0;
        rs_cap = 1'b0; lsb_cap = 1'b0;
        tick(); tick();
        n_checks++;
        if ({rs_assign_ena, lsb_assign_ena, out_count, out_op, out_Qj, out_Qk,
             out_Vj, out_Vk, out_imm, out_pc, out_rd_rob} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs strobes=%b%b count=%0d op=%h Vj=%h Vk=%h required all zero",
                     rs_assign_ena, lsb_assign_ena, out_count, out_op, out_Vj, out_Vk);
        end else $display("reset outputs zero");
        rst = 1'b0; ena = 1'b1;
        tick();
        n_checks++;
        if (out_ready !== 1'b1 || out_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release ready=%b count=%0d required ready=1 count=0", out_ready, out_count);
        end else $display("reset released ready=1 count=0");
    endtask

    task automatic test_single_alu();
        disp_t d, got, want;
        int pcyc, gcyc;
        rs_cap = 1'b1; lsb_cap = 1'b0;
        d = mk(1'b0, 6'h01, 4'h0, 32'd5, 4'h0, 32'd7, 32'h10, 32'h100, 4'h2);
        push_one(d, 1'b1, d, 1'b1);
        pcyc = cyc;
        wait_obs(1, 10);
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_strobe_count got=%0d required=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            gcyc = obs_cyc.pop_front();
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_checks++;
            if (gcyc != pcyc + 1) begin
                n_fail++;
                $display("FAIL single_latency strobe_edge=%0d required=%0d", gcyc, pcyc + 1);
            end
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL single_dispatch got=%h required=%h", got, want);
            end else $display("dispatch single rs Vj=%0d Vk=%0d edge=%0d", got.vj, got.vk, gcyc);
        end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_full_queue();
        disp_t d, e, got, want;
        int c0, c;
        rs_cap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = mk(1'b0, 6'(8 + i), 4'h0, 32'(100 + i), 4'h0, 32'(200 + i),
                   32'(i), 32'h1000 + 32'(4 * i), 4'(i + 1));
            e = d;
            if (i % 2 == 0) e.rd = 4'h0;
            push_one(d, logic'(i % 2), e, 1'b1);
        end
        n_checks++;
        if (out_ready !== 1'b0 || out_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_state ready=%b count=%0d required ready=0 count=4", out_ready, out_count);
        end else $display("queue full ready=0 count=4");
        d = mk(1'b0, 6'h3F, 4'h0, 32'hBAD, 4'h0, 32'hBAD, 32'h0, 32'h0, 4'h0);
        push_one(d, 1'b0, d, 1'b0);
        n_checks++;
        if (out_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_reject count=%0d required=4", out_count);
        end else $display("fifth push rejected count=4");
        rs_cap = 1'b1;
        tick();
        n_checks++;
        if (out_ready !== 1'b1 || out_count !== 3'd3) begin
            n_fail++;
            $display("FAIL full_first_pop ready=%b count=%0d required ready=1 count=3", out_ready, out_count);
        end else $display("first pop ready=1 count=3");
        wait_obs(4, 12);
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL full_strobe_count got=%0d required=4", obs_q.size());
        end
        c0 = (obs_cyc.size() > 0) ? obs_cyc[0] : 0;
        for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            c    = obs_cyc.pop_front();
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want || c != c0 + k) begin
                n_fail++;
                $display("FAIL full_order[%0d] got=%h edge=%0d required=%h edge=%0d", k, got, c, want, c0 + k);
            end else $display("dispatch full[%0d] op=%h Vj=%0d rd=%0d", k, got.op, got.vj, got.rd);
        end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        rs_cap = 1'b0;
    endtask

    task automatic test_snoop();
        disp_t d, e, got, want;
        d = mk(1'b0, 6'h03, 4'h3, 32'h0, 4'h0, 32'h9, 32'h20, 32'h200, 4'h5);
        e = d; e.qj = 4'h0; e.vj = 32'hDEAD;
        for (int sc = 0; sc < 3; sc++) begin
            rs_cap = 1'b0;
            if (sc == 2) begin alu_tag = 4'h3; alu_data = 32'hDEAD; end
            push_one(d, 1'b1, e, 1'b1);
            alu_tag = 4'h0; alu_data = 32'h0;
            if (sc == 0) begin
                alu_tag = 4'h3; alu_data = 32'hDEAD;
                tick();
                alu_tag = 4'h0; alu_data = 32'h0;
                rs_cap = 1'b1;
            end else if (sc == 1) begin
                rs_cap = 1'b1; alu_tag = 4'h3; alu_data = 32'hDEAD;
                tick();
                alu_tag = 4'h0; alu_data = 32'h0;
            end else begin
                rs_cap = 1'b1;
            end
            wait_obs(1, 10);
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL snoop_timeout case=%0d no dispatch, required one", sc);
            end else begin
                void'(obs_cyc.pop_front());
                got  = obs_q.pop_front();
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL snoop case=%0d got Qj=%h Vj=%h required Qj=%h Vj=%h", sc, got.qj, got.vj, want.qj, want.vj);
                end else $display("dispatch snoop case=%0d Qj=%0d Vj=%h", sc, got.qj, got.vj);
            end
            exp_q.delete();
        end
        rs_cap = 1'b0;
    endtask

    task automatic test_cdb_priority();
        disp_t d, e, got, want;
        rs_cap = 1'b0;
        d = mk(1'b0, 6'h04, 4'h0, 32'h77, 4'h5, 32'h0, 32'h30, 32'h300, 4'h6);
        e = d; e.qk = 4'h0; e.vk = 32'h22;
        push_one(d, 1'b1, e, 1'b1);
        alu_tag = 4'h5; alu_data = 32'h11; ls_tag = 4'h5; ls_data = 32'h22;
        tick();
        // Tag 0 broadcast coinciding with dispatch must leave Vj alone.
        alu_tag = 4'h0; alu_data = 32'h99; ls_tag = 4'h0; ls_data = 32'h88;
        rs_cap = 1'b1;
        tick();
        alu_data = 32'h0; ls_data = 32'h0;
        wait_obs(1, 10);
        n_checks++;
        if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL priority_timeout no dispatch, required one");
        end else begin
            void'(obs_cyc.pop_front());
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            if (got !== want) begin
                n_fail++;
                $display("FAIL cdb_priority got Vj=%h Qk=%h Vk=%h required Vj=%h Qk=%h Vk=%h",
                         got.vj, got.qk, got.vk, want.vj, want.qk, want.vk);
            end else $display("dispatch priority Vj=%h Vk=%h", got.vj, got.vk);
        end
        exp_q.delete();
        rs_cap = 1'b0;
    endtask

    task automatic test_head_block();
        disp_t d1, d2, got, want;
        int c0, c;
        rs_cap = 1'b1; lsb_cap = 1'b0;
        d1 = mk(1'b1, 6'h10, 4'h0, 32'h1, 4'h0, 32'h2, 32'h40, 32'h400, 4'h7);
        d2 = mk(1'b0, 6'h11, 4'h0, 32'h3, 4'h0, 32'h4, 32'h44, 32'h404, 4'h8);
        push_one(d1, 1'b1, d1, 1'b1);
        push_one(d2, 1'b1, d2, 1'b1);
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != 0 || out_count !== 3'd2) begin
            n_fail++;
            $display("FAIL head_block strobes=%0d count=%0d required strobes=0 count=2", obs_q.size(), out_count);
        end else $display("head ls entry blocks alu entry count=2");
        lsb_cap = 1'b1;
        wait_obs(2, 10);
        c0 = (obs_cyc.size() > 0) ? obs_cyc[0] : 0;
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL head_release_count got=%0d required=2", obs_q.size());
        end
        for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            c    = obs_cyc.pop_front();
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want || c != c0 + k) begin
                n_fail++;
                $display("FAIL head_order[%0d] got=%h edge=%0d required=%h edge=%0d", k, got, c, want, c0 + k);
            end else $display("dispatch head[%0d] %s op=%h", k, got.is_ls ? "lsb" : "rs", got.op);
        end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        rs_cap = 1'b0; lsb_cap = 1'b0;
    endtask

    task automatic test_flush();
        disp_t d;
        rs_cap = 1'b0; lsb_cap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = mk(logic'(i % 2), 6'(20 + i), 4'h0, 32'(i), 4'h0, 32'(i), 32'h0, 32'(i), 4'h1);
            push_one(d, 1'b1, d, 1'b0);
        end
        flush = 1'b1;
        push_one(d, 1'b1, d, 1'b0);
        flush = 1'b0;
        n_checks++;
        if (out_count !== 3'd0 || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear count=%0d ready=%b required count=0 ready=1", out_count, out_ready);
        end else $display("flush cleared queue count=0");
        rs_cap = 1'b1; lsb_cap = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL flush_no_strobe got=%0d strobes required=0", obs_q.size());
        end else $display("no dispatch after flush");
        obs_q.delete(); obs_cyc.delete();
        rs_cap = 1'b0; lsb_cap = 1'b0;
    endtask

    task automatic test_ena();
        disp_t d, got, want;
        rs_cap = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = mk(1'b0, 6'(40 + i), 4'h0, 32'h500 + 32'(i), 4'h0, 32'h600, 32'h8, 32'h800 + 32'(i), 4'h9);
            push_one(d, 1'b1, d, 1'b1);
        end
        ena = 1'b0; rs_cap = 1'b1;
        d = mk(1'b0, 6'h3E, 4'h0, 32'hF00, 4'h0, 32'hF00, 32'h0, 32'h0, 4'h0);
        in_op = d.op; in_Vj = d.vj; in_Vk = d.vk; in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        n_checks++;
        if (obs_q.size() != 0 || out_count !== 3'd2) begin
            n_fail++;
            $display("FAIL ena_freeze strobes=%0d count=%0d required strobes=0 count=2", obs_q.size(), out_count);
        end else $display("ena low froze queue count=2");
        ena = 1'b1;
        tick();
        ena = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != 1 || out_count !== 3'd1) begin
            n_fail++;
            $display("FAIL ena_single strobes=%0d count=%0d required strobes=1 count=1", obs_q.size(), out_count);
        end else $display("one dispatch then frozen count=1");
        ena = 1'b1;
        wait_obs(2, 10);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            void'(obs_cyc.pop_front());
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL ena_dispatch got=%h required=%h", got, want);
            end else $display("dispatch ena op=%h pc=%h", got.op, got.pc);
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL ena_leftover expected_left=%0d observed_left=%0d required 0/0", exp_q.size(), obs_q.size());
        end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        rs_cap = 1'b0;
    endtask

    task automatic test_rst_async();
        disp_t d;
        rs_cap = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = mk(1'b0, 6'(50 + i), 4'h0, 32'h1, 4'h0, 32'h2, 32'h3, 32'h4, 4'h1);
            push_one(d, 1'b1, d, 1'b0);
        end
        rs_cap = 1'b1;
        tick();
        n_checks++;
        if (rs_assign_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_strobe rs=%b required=1", rs_assign_ena);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (rs_assign_ena !== 1'b0 || lsb_assign_ena !== 1'b0 || out_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_async rs=%b lsb=%b count=%0d required 0 0 0", rs_assign_ena, lsb_assign_ena, out_count);
        end else $display("async reset dropped strobe count=0");
        #2 rst = 1'b0;
        tick();
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != 0 || out_count !== 3'd0 || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after strobes=%0d count=%0d ready=%b required 0 0 1", obs_q.size(), out_count, out_ready);
        end else $display("queue empty after reset");
        obs_q.delete(); obs_cyc.delete();
        rs_cap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_full_queue();
        test_snoop();
        test_cdb_priority();
        test_head_block();
        test_flush();
        test_ena();
        test_rst_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
